processing_element: RTL and testbench
=====================================

# processing_element

Weight-stationary multiply-accumulate cell for the systolic-array core of the deep-learning accelerator. Each cell holds one signed weight and forwards its activation input one cell to the right with a one-cycle delay. Each cycle it adds weight × activation to the partial sum arriving from above and registers the result for the cell below. Cells tile into rows and columns purely by abutment of ToRight→Input and PsumOut→PsumIn.

## Interface
- DATA_WIDTH, 8: width of the weight, the activation input and ToRight; signed two's complement; ≥2.
- ACCUMULATOR_DATA_WIDTH, 32: width of PsumIn and PsumOut; signed; must be ≥ 2·DATA_WIDTH.
- CLK  input  1  clock; all state changes on the rising edge.
- SYNC_RST  input  1  reset; synchronous, active-high.
- EN  input  1  compute enable; advances the activation pipe and the partial-sum register.
- LOAD  input  1  weight load strobe; captures Input into the weight register.
- Input  input  DATA_WIDTH  signed activation, or the weight value while LOAD=1.
- PsumIn  input  ACCUMULATOR_DATA_WIDTH  signed partial sum from the cell above.
- ToRight  output  DATA_WIDTH  registered copy of Input, feeding the next cell in the row.
- PsumOut  output  ACCUMULATOR_DATA_WIDTH  registered partial sum, feeding the next cell in the column.

## Operation
- State: the weight register W (DATA_WIDTH), the ToRight register and the PsumOut register. There is no FSM.
- Reset: SYNC_RST=1 at a rising edge sets W=0, ToRight=0 and PsumOut=0. Reset has priority over LOAD and EN.
- Load: LOAD=1 sets W←Input. W then holds until the next load or reset, independent of EN.
- Compute, when EN=1:
  - ToRight←Input.
  - PsumOut←PsumIn + W·Input.
- Arithmetic: the product is a full signed DATA_WIDTH×DATA_WIDTH multiply, giving a 2·DATA_WIDTH-bit result. The product is sign-extended to ACCUMULATOR_DATA_WIDTH and added to PsumIn.
- Overflow: without the configuration macro, the sum wraps modulo 2^ACCUMULATOR_DATA_WIDTH (two's complement).
- EN=0: ToRight and PsumOut hold their values, and PsumIn is ignored.
- LOAD=1 and EN=1 together:
  - Both actions occur.
  - The MAC uses the W value held before the edge.
  - ToRight takes Input, which is the same value loaded into W.
- LOAD alone does not change ToRight or PsumOut.
- No combinational path exists from any input to any output.

## Timing
- Weight load latency: 1 cycle. A LOAD sampled at edge n makes W usable by a MAC sampled at edge n+1.
- Activation forward latency: 1 cycle, from Input at edge n to ToRight after edge n.
- Partial-sum latency: 1 cycle. PsumOut after edge n reflects PsumIn, Input and W sampled at edge n.
- Reset asserted mid-stream: all outputs read 0 after the reset edge. Stimulus applied in the same cycle as reset is discarded.
- Throughput: one MAC per cycle while EN=1.

## Configuration
- Macro PE_SATURATE_EN.
- Defined:
  - The accumulate saturates to the range [−2^(ACCUMULATOR_DATA_WIDTH−1), 2^(ACCUMULATOR_DATA_WIDTH−1)−1].
  - Positive overflow clamps to the maximum and negative overflow clamps to the minimum.
  - Overflow is detected from the sign bits of the operands and the sum.
- Undefined: two's-complement wrap-around, with no saturation logic synthesised.
- Latency and all other behaviour are identical in both builds.

## Test plan
- Reset: SYNC_RST=1 for one edge with arbitrary inputs -> W=0, ToRight=0, PsumOut=0.
- Load then MAC:
  - Cycle 1: LOAD=1, Input=50.
  - Cycle 2: LOAD=0, EN=1, Input=4, PsumIn=1.
  - Required: PsumOut=201 and ToRight=4 after that edge.
  - Holding the same inputs for another edge keeps PsumOut at 201.
- Signed operands and hold:
  - W=−3, Input=−7, PsumIn=−100, EN=1 -> PsumOut=−79, ToRight=−7.
  - Then EN=0 with changed inputs -> PsumOut=−79 and ToRight=−7 unchanged.
- Simultaneous LOAD+EN:
  - W=2, then LOAD=1, EN=1, Input=10, PsumIn=0 -> PsumOut=20 (old weight), W=10.
  - The next MAC with Input=1 and PsumIn=0 gives PsumOut=10.
- Overflow: W=−128, Input=−128, PsumIn=2^31−1.
  - Without PE_SATURATE_EN -> PsumOut=−2^31+16383.
  - With PE_SATURATE_EN -> PsumOut=2^31−1.
- Mid-stream reset: EN=1 with MACs running, SYNC_RST=1 for one edge -> all outputs 0.
  - After reset, a MAC with Input=5 and PsumIn=3 gives PsumOut=3, because W was cleared.

Source files
------------

// File: rtl/processing_element.sv
// Weight-stationary MAC cell for a systolic array: holds one signed weight, forwards the
// activation right and accumulates down. Optional build macro: PE_SATURATE_EN (clamp accumulate).
module processing_element #(
    parameter int DATA_WIDTH             = 8,
    parameter int ACCUMULATOR_DATA_WIDTH = 32
) (
    input  logic                                     CLK,
    input  logic                                     SYNC_RST,
    input  logic                                     EN,
    input  logic                                     LOAD,
    input  logic signed [DATA_WIDTH-1:0]             Input,
    input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumIn,
    output logic signed [DATA_WIDTH-1:0]             ToRight,
    output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumOut
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [DATA_WIDTH-1:0]             r_weight;
    logic signed [DATA_WIDTH-1:0]             r_to_right;
    logic signed [ACCUMULATOR_DATA_WIDTH-1:0] r_psum;

    logic signed [PROD_WIDTH-1:0]             w_product;
    logic signed [ACCUMULATOR_DATA_WIDTH-1:0] w_product_ext;
    logic signed [ACCUMULATOR_DATA_WIDTH-1:0] w_raw_sum;
    logic signed [ACCUMULATOR_DATA_WIDTH-1:0] w_next_psum;

`ifdef PE_SATURATE_EN
    localparam logic signed [ACCUMULATOR_DATA_WIDTH-1:0] ACC_MAX =
        {1'b0, {(ACCUMULATOR_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUMULATOR_DATA_WIDTH-1:0] ACC_MIN =
        {1'b1, {(ACCUMULATOR_DATA_WIDTH-1){1'b0}}};

    // Overflow only when both addends share a sign and the sum's sign differs from it.
    function automatic logic signed [ACCUMULATOR_DATA_WIDTH-1:0] sat_sum(
        input logic signed [ACCUMULATOR_DATA_WIDTH-1:0] a,
        input logic signed [ACCUMULATOR_DATA_WIDTH-1:0] b,
        input logic signed [ACCUMULATOR_DATA_WIDTH-1:0] s
    );
        logic sa;
        logic sb;
        logic ss;
        sa = a[ACCUMULATOR_DATA_WIDTH-1];
        sb = b[ACCUMULATOR_DATA_WIDTH-1];
        ss = s[ACCUMULATOR_DATA_WIDTH-1];
        if ((sa == 1'b0) && (sb == 1'b0) && (ss == 1'b1)) begin
            sat_sum = ACC_MAX;
        end else if ((sa == 1'b1) && (sb == 1'b1) && (ss == 1'b0)) begin
            sat_sum = ACC_MIN;
        end else begin
            sat_sum = s;
        end
    endfunction
`endif

    // Full signed product, sign-extended to the accumulator width, plus the incoming partial sum.
    always_comb begin
        w_product     = r_weight * Input;
        w_product_ext = ACCUMULATOR_DATA_WIDTH'(w_product);
        w_raw_sum     = PsumIn + w_product_ext;
`ifdef PE_SATURATE_EN
        w_next_psum   = sat_sum(PsumIn, w_product_ext, w_raw_sum);
`else
        w_next_psum   = w_raw_sum;
`endif
    end

    // Weight, activation pipe and partial-sum registers; reset overrides LOAD and EN.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            r_weight   <= {DATA_WIDTH{1'b0}};
            r_to_right <= {DATA_WIDTH{1'b0}};
            r_psum     <= {ACCUMULATOR_DATA_WIDTH{1'b0}};
        end else begin
            // The MAC above reads the pre-edge weight, so LOAD with EN uses the old weight.
            if (LOAD) begin
                r_weight <= Input;
            end else begin
                r_weight <= r_weight;
            end
            if (EN) begin
                r_to_right <= Input;
                r_psum     <= w_next_psum;
            end else begin
                r_to_right <= r_to_right;
                r_psum     <= r_psum;
            end
        end
    end

    assign ToRight = r_to_right;
    assign PsumOut = r_psum;

endmodule

// File: tb/tb_processing_element.sv
// Directed self-checking bench for processing_element; expected values are hand-computed.
module tb_processing_element;

    logic               CLK;
    logic               SYNC_RST;
    logic               EN;
    logic               LOAD;
    logic signed [7:0]  Input;
    logic signed [31:0] PsumIn;
    logic signed [7:0]  ToRight;
    logic signed [31:0] PsumOut;

    int errors = 0;
    int checks = 0;

    processing_element #(
        .DATA_WIDTH             (8),
        .ACCUMULATOR_DATA_WIDTH (32)
    ) dut (
        .CLK      (CLK),
        .SYNC_RST (SYNC_RST),
        .EN       (EN),
        .LOAD     (LOAD),
        .Input    (Input),
        .PsumIn   (PsumIn),
        .ToRight  (ToRight),
        .PsumOut  (PsumOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input logic rst, input logic ld, input logic en,
                         input logic signed [7:0] din, input logic signed [31:0] pin);
        @(negedge CLK);
        SYNC_RST = rst;
        LOAD     = ld;
        EN       = en;
        Input    = din;
        PsumIn   = pin;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input longint observed, input longint expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        SYNC_RST = 1'b1;
        LOAD     = 1'b0;
        EN       = 1'b0;
        Input    = 8'sd0;
        PsumIn   = 32'sd0;

        // Reset with arbitrary live inputs
        drive(1'b1, 1'b1, 1'b1, 8'sd77, 32'sd999);
        check("reset_toright", ToRight, 0);
        check("reset_psum", PsumOut, 0);
        drive(1'b0, 1'b0, 1'b1, 8'sd9, 32'sd5);
        check("reset_weight_zero_psum", PsumOut, 5);
        check("reset_weight_zero_toright", ToRight, 9);

        // Load 50 alone leaves outputs untouched, then MAC
        drive(1'b0, 1'b1, 1'b0, 8'sd50, 32'sd12345);
        check("load_only_toright", ToRight, 9);
        check("load_only_psum", PsumOut, 5);
        drive(1'b0, 1'b0, 1'b1, 8'sd4, 32'sd1);
        check("mac_50x4_psum", PsumOut, 201);
        check("mac_50x4_toright", ToRight, 4);
        drive(1'b0, 1'b0, 1'b1, 8'sd4, 32'sd1);
        check("mac_repeat_psum", PsumOut, 201);

        // Signed operands, then hold with EN=0
        drive(1'b0, 1'b1, 1'b0, -8'sd3, 32'sd0);
        drive(1'b0, 1'b0, 1'b1, -8'sd7, -32'sd100);
        check("signed_psum", PsumOut, -79);
        check("signed_toright", ToRight, -7);
        drive(1'b0, 1'b0, 1'b0, 8'sd33, 32'sd555);
        check("hold_psum", PsumOut, -79);
        check("hold_toright", ToRight, -7);

        // Simultaneous LOAD and EN uses the old weight
        drive(1'b0, 1'b1, 1'b0, 8'sd2, 32'sd0);
        drive(1'b0, 1'b1, 1'b1, 8'sd10, 32'sd0);
        check("load_en_psum", PsumOut, 20);
        check("load_en_toright", ToRight, 10);
        drive(1'b0, 1'b0, 1'b1, 8'sd1, 32'sd0);
        check("load_en_new_weight", PsumOut, 10);

        // Positive overflow: 2^31-1 + 16384
        drive(1'b0, 1'b1, 1'b0, -8'sd128, 32'sd0);
        drive(1'b0, 1'b0, 1'b1, -8'sd128, 32'sh7FFF_FFFF);
`ifdef PE_SATURATE_EN
        check("pos_overflow", PsumOut, 64'sd2147483647);
`else
        check("pos_overflow", PsumOut, -64'sd2147467265);
`endif
        // Negative overflow: -2^31 + (-16256)
        drive(1'b0, 1'b0, 1'b1, 8'sd127, 32'sh8000_0000);
`ifdef PE_SATURATE_EN
        check("neg_overflow", PsumOut, -64'sd2147483648);
`else
        check("neg_overflow", PsumOut, 64'sd2147467392);
`endif

        // Mid-stream reset
        drive(1'b0, 1'b1, 1'b0, 8'sd3, 32'sd0);
        drive(1'b0, 1'b0, 1'b1, 8'sd6, 32'sd7);
        check("stream_mac1", PsumOut, 25);
        drive(1'b0, 1'b0, 1'b1, 8'sd2, 32'sd1);
        check("stream_mac2", PsumOut, 7);
        drive(1'b1, 1'b0, 1'b1, 8'sd100, 32'sd100);
        check("midreset_psum", PsumOut, 0);
        check("midreset_toright", ToRight, 0);
        drive(1'b0, 1'b0, 1'b1, 8'sd5, 32'sd3);
        check("post_reset_psum", PsumOut, 3);
        check("post_reset_toright", ToRight, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
